game_score_ctrl: RTL and testbench
==================================

// Module: game_score_ctrl
// PURPOSE
//  Game sequencer feeding the seven-segment scan block. Runs the round state
//  machine (IDLE/READY/PLAY/OVER), the 1-second tick divider, the PLAY-phase
//  seconds countdown, and the 3-digit BCD score with hit/miss updates.
//  The state, countDown and score100/10/1 outputs connect 1:1 to the display
//  scanner; state==3'b010 (PLAY) is the code the scanner uses to show countDown.
// PARAMETERS
//  TICK_DIV     50_000_000  Game_clk cycles per 1-second tick (>=2)
//  COUNT_START  7           PLAY length in seconds, loaded into countDown (1..7)
//  READY_TICKS  2           seconds spent in READY before PLAY (1..15)
// PORTS
//  Game_clk   in   1  single clock; all state changes on its rising edge
//  reset      in   1  asynchronous, active-low; clears everything
//  start      in   1  start button level, already synchronised; rising edge acts
//  hit        in   1  one-cycle pulse: +1 score (PLAY only)
//  miss       in   1  one-cycle pulse: -1 score (PLAY only)
//  state      out  3  IDLE=000 READY=001 PLAY=010 OVER=100
//  countDown  out  3  seconds remaining in PLAY; 0 outside PLAY
//  score100   out  4  BCD hundreds digit (0..9)
//  score10    out  4  BCD tens digit (0..9)
//  score1     out  4  BCD ones digit (0..9)
//  game_over  out  1  one-cycle pulse on the PLAY->OVER edge
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, countDown=0, all score digits=0,
//   game_over=0, tick counter=0, start edge register=0. Reset mid-round aborts.
//  start_rise = start & ~start_q (start_q is start registered every cycle).
//  Tick: counter runs 0..TICK_DIV-1; tick=1 for one cycle when it hits TICK_DIV-1.
//   The counter clears on every state change, so the first tick of a state
//   arrives exactly TICK_DIV cycles after entry.
//  FSM (all transitions registered, effective on the same edge as the cause):
//   IDLE : start_rise -> READY; scores cleared to 000.
//   READY: counts ticks; on the READY_TICKS-th tick -> PLAY, countDown=COUNT_START.
//          start/hit/miss ignored.
//   PLAY : tick & countDown>1 -> countDown-1.
//          tick & countDown==1 -> countDown=0, state=OVER, game_over=1 that cycle.
//          hit/miss apply on the edge they are sampled; visible 1 cycle later.
//   OVER : score and countDown=0 held; start_rise -> READY, scores cleared to 000.
//   Unused state codes -> IDLE on the next edge.
//  Score arithmetic (3-digit BCD, never a non-BCD digit):
//   hit only : +1 with decimal carry (009->010, 099->100); saturates at 999.
//   miss only: -1 with decimal borrow (010->009, 100->099); floor at 000.
//   hit & miss in the same cycle: no change.
//   hit/miss on the final tick edge still count (applied before entering OVER).
//  start_rise while in READY or PLAY: ignored (no restart).
// TESTING (TICK_DIV=4, COUNT_START=3, READY_TICKS=2 unless noted)
//  1 Reset release, start rise -> READY next edge; PLAY 8 cycles later with
//    countDown=3; 3,2,1 each held 4 cycles; then OVER, countDown=0, game_over 1 cycle.
//  2 PLAY, 12 hit pulses -> digits 0/1/2; start score 099 + hit -> 100;
//    start 999 + hit -> 999 (saturates).
//  3 Score 010 + miss -> 009; score 000 + miss -> 000; hit&miss together at
//    057 -> 057.
//  4 Hit in IDLE/READY/OVER -> score unchanged; start held high across the
//    OVER entry -> no restart until start falls and rises again.
//  5 OVER with score 042, start rise -> READY, score 000, full round repeats.
//  6 Assert reset mid-PLAY (countDown=2, score 015) -> immediately IDLE, 0, 000,
//    with no clock edge; after release, start rise begins a clean round.

Source files
------------

// File: rtl/game_score_if.sv
// Game sequencer bus: button/hit inputs plus the round status and BCD score
// that drive the seven-segment scanner.
interface game_score_if;
   logic       start;
   logic       hit;
   logic       miss;
   logic [2:0] state;
   logic [2:0] countDown;
   logic [3:0] score100;
   logic [3:0] score10;
   logic [3:0] score1;
   logic       game_over;

   modport master (
      output start, hit, miss,
      input  state, countDown, score100, score10, score1, game_over
   );

   modport slave (
      input  start, hit, miss,
      output state, countDown, score100, score10, score1, game_over
   );
endinterface

// File: rtl/game_score_ctrl.sv
// Round sequencer: IDLE/READY/PLAY/OVER state machine, 1-second tick divider,
// PLAY countdown and saturating 3-digit BCD score.
module game_score_ctrl #(
   parameter int TICK_DIV    = 50_000_000,
   parameter int COUNT_START = 7,
   parameter int READY_TICKS = 2
) (
   input  logic         Game_clk,
   input  logic         reset,
   game_score_if.slave  bus
);

   localparam int             TW         = $clog2(TICK_DIV);
   localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [3:0]     READY_LAST = 4'(READY_TICKS - 1);
   localparam logic [2:0]     CD_START   = 3'(COUNT_START);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      READY = 3'b001,
      PLAY  = 3'b010,
      OVER  = 3'b100
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    rdy_cnt_q, rdy_cnt_d;
   logic [2:0]    cd_q, cd_d;
   logic [11:0]   score_q, score_d;
   logic          go_q, go_d;
   logic          start_q;
   logic          tick;
   logic          start_rise;

   // Decimal +1 that stops at 999 so a digit never leaves 0..9.
   function automatic logic [11:0] bcd_inc_sat(input logic [11:0] s);
      logic [11:0] r;
      r = s;
      if (s != 12'h999) begin
         if (s[3:0] != 4'd9) begin
            r[3:0] = s[3:0] + 4'd1;
         end else begin
            r[3:0] = 4'd0;
            if (s[7:4] != 4'd9) begin
               r[7:4] = s[7:4] + 4'd1;
            end else begin
               r[7:4]  = 4'd0;
               r[11:8] = s[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   // Decimal -1 with a floor at 000.
   function automatic logic [11:0] bcd_dec_sat(input logic [11:0] s);
      logic [11:0] r;
      r = s;
      if (s != 12'h000) begin
         if (s[3:0] != 4'd0) begin
            r[3:0] = s[3:0] - 4'd1;
         end else begin
            r[3:0] = 4'd9;
            if (s[7:4] != 4'd0) begin
               r[7:4] = s[7:4] - 4'd1;
            end else begin
               r[7:4]  = 4'd9;
               r[11:8] = s[11:8] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign start_rise = bus.start & ~start_q;

   always_comb begin
      state_d   = state_q;
      cd_d      = cd_q;
      score_d   = score_q;
      rdy_cnt_d = rdy_cnt_q;
      go_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_d   = READY;
               score_d   = 12'h000;
               rdy_cnt_d = 4'd0;
            end
         end
         READY: begin
            if (tick) begin
               if (rdy_cnt_q == READY_LAST) begin
                  state_d = PLAY;
                  cd_d    = CD_START;
               end else begin
                  rdy_cnt_d = rdy_cnt_q + 4'd1;
               end
            end
         end
         PLAY: begin
            // Score updates even on the final tick edge, before OVER is entered.
            if (bus.hit && !bus.miss) begin
               score_d = bcd_inc_sat(score_q);
            end else if (bus.miss && !bus.hit) begin
               score_d = bcd_dec_sat(score_q);
            end
            if (tick) begin
               if (cd_q > 3'd1) begin
                  cd_d = cd_q - 3'd1;
               end else begin
                  cd_d    = 3'd0;
                  state_d = OVER;
                  go_d    = 1'b1;
               end
            end
         end
         OVER: begin
            cd_d = 3'd0;
            if (start_rise) begin
               state_d   = READY;
               score_d   = 12'h000;
               rdy_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cd_d    = 3'd0;
         end
      endcase
      // Restart the divider on every state change so each state's first tick
      // lands exactly TICK_DIV cycles after entry.
      tick_cnt_d = (state_d != state_q || tick) ? '0 : tick_cnt_q + 1'b1;
   end

   always_ff @(posedge Game_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         rdy_cnt_q  <= 4'd0;
         cd_q       <= 3'd0;
         score_q    <= 12'h000;
         go_q       <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         rdy_cnt_q  <= rdy_cnt_d;
         cd_q       <= cd_d;
         score_q    <= score_d;
         go_q       <= go_d;
         start_q    <= bus.start;
      end
   end

   assign bus.state     = state_q;
   assign bus.countDown = cd_q;
   assign bus.score100  = score_q[11:8];
   assign bus.score10   = score_q[7:4];
   assign bus.score1    = score_q[3:0];
   assign bus.game_over = go_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Randomised scoreboard bench for game_score_ctrl: a short-tick instance for
// round timing and a long-PLAY instance for score saturation and borrows.
module tb_game_score_ctrl;

   localparam int TD_A = 4;
   localparam int CS_A = 3;
   localparam int RT_A = 2;
   localparam int TD_B = 600;
   localparam int CS_B = 4;
   localparam int RT_B = 1;

   logic Game_clk = 1'b0;
   logic rst_a_n  = 1'b0;
   logic rst_b_n  = 1'b0;

   always #5 Game_clk = ~Game_clk;

   game_score_if bus_a();
   game_score_if bus_b();

   game_score_ctrl #(.TICK_DIV(TD_A), .COUNT_START(CS_A), .READY_TICKS(RT_A)) dut_a (
      .Game_clk(Game_clk),
      .reset   (rst_a_n),
      .bus     (bus_a.slave)
   );

   game_score_ctrl #(.TICK_DIV(TD_B), .COUNT_START(CS_B), .READY_TICKS(RT_B)) dut_b (
      .Game_clk(Game_clk),
      .reset   (rst_b_n),
      .bus     (bus_b.slave)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic [2:0]  cd;
      logic [11:0] sc;
      logic        go;
   } obs_t;

   obs_t exp_qa[$];
   obs_t exp_qb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: phase 0..3 = idle/ready/play/over, elapsed cycles in phase.
   int m_phase[2];
   int m_el[2];
   int m_score[2];
   bit m_sprev[2];
   bit m_go[2];

   function automatic obs_t model_obs(int idx, int td, int cs);
      obs_t o;
      case (m_phase[idx])
         1:       o.st = 3'b001;
         2:       o.st = 3'b010;
         3:       o.st = 3'b100;
         default: o.st = 3'b000;
      endcase
      o.cd = (m_phase[idx] == 2) ? 3'(cs - m_el[idx] / td) : 3'd0;
      o.sc = {4'(m_score[idx] / 100), 4'((m_score[idx] / 10) % 10), 4'(m_score[idx] % 10)};
      o.go = m_go[idx];
      return o;
   endfunction

   task automatic model_reset(int idx);
      m_phase[idx] = 0;
      m_el[idx]    = 0;
      m_score[idx] = 0;
      m_sprev[idx] = 1'b0;
      m_go[idx]    = 1'b0;
   endtask

   task automatic model_step(int idx, int td, int cs, int rt, bit s, bit h, bit m);
      bit rise;
      rise = s && !m_sprev[idx];
      m_sprev[idx] = s;
      m_go[idx] = 1'b0;
      case (m_phase[idx])
         0: if (rise) begin m_phase[idx] = 1; m_el[idx] = 0; m_score[idx] = 0; end
         1: begin
            m_el[idx]++;
            if (m_el[idx] == rt * td) begin m_phase[idx] = 2; m_el[idx] = 0; end
         end
         2: begin
            if (h && !m)      m_score[idx] = (m_score[idx] < 999) ? m_score[idx] + 1 : 999;
            else if (m && !h) m_score[idx] = (m_score[idx] > 0) ? m_score[idx] - 1 : 0;
            m_el[idx]++;
            if (m_el[idx] == cs * td) begin m_phase[idx] = 3; m_el[idx] = 0; m_go[idx] = 1'b1; end
         end
         default: if (rise) begin m_phase[idx] = 1; m_el[idx] = 0; m_score[idx] = 0; end
      endcase
   endtask

   task automatic check(string name, obs_t act, obs_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got st=%b cd=%0d score=%h go=%b, expected st=%b cd=%0d score=%h go=%b",
                  name, $time, act.st, act.cd, act.sc, act.go, exp.st, exp.cd, exp.sc, exp.go);
      end
   endtask

   function automatic obs_t obs_a();
      return {bus_a.state, bus_a.countDown, bus_a.score100, bus_a.score10, bus_a.score1, bus_a.game_over};
   endfunction

   function automatic obs_t obs_b();
      return {bus_b.state, bus_b.countDown, bus_b.score100, bus_b.score10, bus_b.score1, bus_b.game_over};
   endfunction

   // Monitors: compare each registered output set just after the edge it follows.
   always @(posedge Game_clk) begin
      obs_t e;
      #1;
      if (exp_qa.size() > 0) begin
         e = exp_qa.pop_front();
         check("dut_a", obs_a(), e);
      end
   end

   always @(posedge Game_clk) begin
      obs_t e;
      #1;
      if (exp_qb.size() > 0) begin
         e = exp_qb.pop_front();
         check("dut_b", obs_b(), e);
      end
   end

   task automatic cyc_a(bit s, bit h, bit m);
      @(negedge Game_clk);
      bus_a.start = s; bus_a.hit = h; bus_a.miss = m;
      model_step(0, TD_A, CS_A, RT_A, s, h, m);
      exp_qa.push_back(model_obs(0, TD_A, CS_A));
   endtask

   task automatic cyc_b(bit s, bit h, bit m);
      @(negedge Game_clk);
      bus_b.start = s; bus_b.hit = h; bus_b.miss = m;
      model_step(1, TD_B, CS_B, RT_B, s, h, m);
      exp_qb.push_back(model_obs(1, TD_B, CS_B));
   endtask

   task automatic rand_a(int n, int start_pct);
      for (int i = 0; i < n; i++)
         cyc_a(($urandom % 100) < start_pct, ($urandom % 3) != 0, ($urandom % 3) == 0);
   endtask

   // Asynchronous reset between edges: outputs must clear with no clock edge.
   task automatic reset_a();
      @(negedge Game_clk);
      bus_a.start = 1'b0; bus_a.hit = 1'b0; bus_a.miss = 1'b0;
      rst_a_n = 1'b0;
      #1;
      model_reset(0);
      check("reset_async_a", obs_a(), model_obs(0, TD_A, CS_A));
      exp_qa.push_back(model_obs(0, TD_A, CS_A));
      @(negedge Game_clk);
      exp_qa.push_back(model_obs(0, TD_A, CS_A));
      @(negedge Game_clk);
      rst_a_n = 1'b1;
      model_step(0, TD_A, CS_A, RT_A, 1'b0, 1'b0, 1'b0);
      exp_qa.push_back(model_obs(0, TD_A, CS_A));
   endtask

   task automatic reset_b();
      @(negedge Game_clk);
      bus_b.start = 1'b0; bus_b.hit = 1'b0; bus_b.miss = 1'b0;
      rst_b_n = 1'b0;
      #1;
      model_reset(1);
      check("reset_async_b", obs_b(), model_obs(1, TD_B, CS_B));
      @(negedge Game_clk);
      rst_b_n = 1'b1;
      model_step(1, TD_B, CS_B, RT_B, 1'b0, 1'b0, 1'b0);
      exp_qb.push_back(model_obs(1, TD_B, CS_B));
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.hit = 1'b0; bus_a.miss = 1'b0;
      bus_b.start = 1'b0; bus_b.hit = 1'b0; bus_b.miss = 1'b0;
      model_reset(0);
      model_reset(1);
      fork
         begin
            reset_a();
            // Full round, hit every cycle: READY/OVER hits ignored, PLAY gives 012.
            cyc_a(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 25; i++) cyc_a(1'b0, 1'b1, 1'b0);
            // Restart from OVER with start held high through the whole round.
            for (int i = 0; i < 26; i++) cyc_a(1'b1, ($urandom % 2) == 1, ($urandom % 4) == 0);
            cyc_a(1'b0, 1'b0, 1'b0);
            cyc_a(1'b1, 1'b0, 1'b0);
            // Start toggling every cycle during READY/PLAY must not restart.
            for (int i = 0; i < 24; i++) cyc_a(i[0], 1'b1, (i % 5) == 0);
            rand_a(200, 10);
            // Reset mid-PLAY at countDown 2, then a clean round.
            reset_a();
            cyc_a(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 14; i++) cyc_a(1'b0, 1'b1, 1'b0);
            reset_a();
            cyc_a(1'b1, 1'b0, 1'b0);
            rand_a(30, 0);
            cyc_a(1'b0, 1'b0, 1'b0);
         end
         begin
            reset_b();
            cyc_b(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < RT_B * TD_B; i++) cyc_b(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 1005; i++) cyc_b(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 10; i++) cyc_b(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 1050; i++) cyc_b(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < CS_B * TD_B - 2065 + 5; i++)
               cyc_b(1'b0, ($urandom % 2) == 1, ($urandom % 3) == 0);
         end
      join
      repeat (3) @(posedge Game_clk);
      #2;
      n_tests++;
      if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_qa.size(), exp_qb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
